// File: rtl/fb_access_arbiter_if.sv
// Frame-buffer arbiter bus: scan-out read, two player writers, clear control
// and the single-port RAM side. The arbiter uses the slave modport.
interface fb_access_arbiter_if #(
   parameter int unsigned ADDR_W = 19
);
   // scan-out read port
   logic              pix_req;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [2:0]        pix_data;
   logic              pix_valid;

   // player write ports
   logic [1:0]        wr_req;
   logic [9:0]        wr_x0;
   logic [9:0]        wr_y0;
   logic [9:0]        wr_x1;
   logic [9:0]        wr_y1;
   logic [2:0]        wr_data0;
   logic [2:0]        wr_data1;
   logic [1:0]        wr_ack;

   // clear engine control
   logic              clr_start;
   logic              clr_busy;

   // RAM side
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [2:0]        mem_wdata;
   logic [2:0]        mem_rdata;

   modport master (
      output pix_req, DrawX, DrawY,
      input  pix_data, pix_valid,
      output wr_req, wr_x0, wr_y0, wr_x1, wr_y1, wr_data0, wr_data1,
      input  wr_ack,
      output clr_start,
      input  clr_busy,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  pix_req, DrawX, DrawY,
      output pix_data, pix_valid,
      input  wr_req, wr_x0, wr_y0, wr_x1, wr_y1, wr_data0, wr_data1,
      output wr_ack,
      input  clr_start,
      output clr_busy,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer access scheduler. Scan-out reads win every cycle,
// then the optional full-screen clear engine, then the two player writers
// round-robin. The clear engine is built only when FB_CLEAR_EN is defined.
module fb_access_arbiter #(
   parameter int unsigned H_RES  = 640,
   parameter int unsigned V_RES  = 480,
   parameter int unsigned ADDR_W = 19
) (
   input  logic               Clk,
   input  logic               Reset_n,
   fb_access_arbiter_if.slave bus
);

   localparam int unsigned CRD_W = 10;
   localparam int unsigned PIX_W = 3;

   typedef enum logic [1:0] {
      G_NONE   = 2'd0,
      G_READ   = 2'd1,
      G_CLEAR  = 2'd2,
      G_PLAYER = 2'd3
   } grant_e;

   // Linear address y*H_RES + x, truncated to ADDR_W bits.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [CRD_W-1:0] x,
                                                  input logic [CRD_W-1:0] y);
      logic [ADDR_W-1:0] row;
      row = ADDR_W'(y) * ADDR_W'(H_RES);
      return row + ADDR_W'(x);
   endfunction

   // True when the coordinate lies inside the visible frame.
   function automatic logic on_screen(input logic [CRD_W-1:0] x,
                                      input logic [CRD_W-1:0] y);
      return (32'(x) < H_RES) && (32'(y) < V_RES);
   endfunction

   grant_e              grant_c;
   logic                player_c;
   logic [1:0]          ack_c;
   logic                clr_active_c;
   logic [ADDR_W-1:0]   clr_cnt;
   logic                rd_ok_c;
   logic                wr_ok_c;
   logic [CRD_W-1:0]    wr_x_c;
   logic [CRD_W-1:0]    wr_y_c;
   logic [PIX_W-1:0]    wr_data_c;

   logic                rr_last;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_we_q;
   logic [PIX_W-1:0]    mem_wdata_q;
   logic [1:0]          rd_valid_q;
   logic [1:0]          rd_blank_q;
   logic                pix_valid_q;
   logic [PIX_W-1:0]    pix_data_q;

   // Per-cycle grant: read, then clear, then players (other-than-last on a tie).
   always_comb begin
      grant_c  = G_NONE;
      player_c = 1'b0;
      ack_c    = 2'b00;
      if (bus.pix_req) begin
         grant_c = G_READ;
      end else if (clr_active_c) begin
         grant_c = G_CLEAR;
      end else if (bus.wr_req != 2'b00) begin
         grant_c = G_PLAYER;
         if (bus.wr_req == 2'b11) begin
            player_c = ~rr_last;
         end else begin
            player_c = bus.wr_req[1];
         end
         ack_c = player_c ? 2'b10 : 2'b01;
      end
   end

   // Ack is combinational; held low while reset is asserted.
   assign bus.wr_ack = Reset_n ? ack_c : 2'b00;

   // Operands of the granted player and range qualifiers.
   always_comb begin
      wr_x_c    = player_c ? bus.wr_x1    : bus.wr_x0;
      wr_y_c    = player_c ? bus.wr_y1    : bus.wr_y0;
      wr_data_c = player_c ? bus.wr_data1 : bus.wr_data0;
      wr_ok_c   = on_screen(wr_x_c, wr_y_c);
      rd_ok_c   = on_screen(bus.DrawX, bus.DrawY);
   end

   // Round-robin pointer: most recently granted player.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_last <= 1'b1;
      end else if (grant_c == G_PLAYER) begin
         rr_last <= player_c;
      end
   end

   // RAM command register; address and data hold when no access is launched.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         case (grant_c)
            G_READ: begin
               mem_we_q <= 1'b0;
               if (rd_ok_c) begin
                  mem_addr_q <= pix_addr(bus.DrawX, bus.DrawY);
               end
            end
            G_CLEAR: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= clr_cnt;
               mem_wdata_q <= '0;
            end
            G_PLAYER: begin
               mem_we_q <= wr_ok_c;
               if (wr_ok_c) begin
                  mem_addr_q  <= pix_addr(wr_x_c, wr_y_c);
                  mem_wdata_q <= wr_data_c;
               end
            end
            default: begin
               mem_we_q <= 1'b0;
            end
         endcase
      end
   end

   // Read pipeline: request -> address at RAM -> data back -> registered index.
   // Off-screen reads travel with a blank flag and return index 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_valid_q  <= 2'b00;
         rd_blank_q  <= 2'b00;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
      end else begin
         rd_valid_q  <= {rd_valid_q[0], bus.pix_req};
         rd_blank_q  <= {rd_blank_q[0], ~rd_ok_c};
         pix_valid_q <= rd_valid_q[1];
         if (rd_valid_q[1]) begin
            pix_data_q <= rd_blank_q[1] ? '0 : bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_data  = pix_data_q;

`ifdef FB_CLEAR_EN
   localparam int unsigned       FB_SIZE   = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } clr_state_e;

   clr_state_e clr_state;
   clr_state_e clr_state_nxt;
   logic       clr_write_c;
   logic       clr_busy_q;

   // Clear FSM state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clr_state <= S_IDLE;
      end else begin
         clr_state <= clr_state_nxt;
      end
   end

   // Clear FSM next state; a start request during a clear is ignored.
   always_comb begin
      clr_state_nxt = clr_state;
      case (clr_state)
         S_IDLE: begin
            if (bus.clr_start) begin
               clr_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (clr_write_c && (clr_cnt == LAST_ADDR)) begin
               clr_state_nxt = S_IDLE;
            end
         end
         default: begin
            clr_state_nxt = S_IDLE;
         end
      endcase
   end

   // Clear FSM outputs: block players, write whenever the read slot is free.
   always_comb begin
      clr_active_c = 1'b0;
      clr_write_c  = 1'b0;
      if (clr_state == S_CLEAR) begin
         clr_active_c = 1'b1;
         clr_write_c  = ~bus.pix_req;
      end
   end

   // Clear address counter; parked at 0 outside a clear.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clr_cnt <= '0;
      end else if (clr_state == S_IDLE) begin
         clr_cnt <= '0;
      end else if (clr_write_c) begin
         clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_W'(1);
      end
   end

   // Busy flag follows the FSM state registered from its next value.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clr_busy_q <= 1'b0;
      end else begin
         clr_busy_q <= (clr_state_nxt == S_CLEAR);
      end
   end

   assign bus.clr_busy = clr_busy_q;
`else
   logic unused_clr_start;

   assign clr_active_c     = 1'b0;
   assign clr_cnt          = '0;
   assign bus.clr_busy     = 1'b0;
   assign unused_clr_start = bus.clr_start;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter with a cycle-level reference model
// (expected image array, read-return queue, round-robin pointer).
// Clear-engine scenarios are selected by FB_CLEAR_EN.
module tb_fb_access_arbiter;

   localparam int unsigned H   = 640;
   localparam int unsigned V   = 480;
   localparam int unsigned AW  = 19;
   localparam int unsigned FBS = H * V;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   always #5 Clk = ~Clk;

   fb_access_arbiter_if #(.ADDR_W(AW)) bus ();

   fb_access_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // RAM device: 1-cycle read latency, write at the edge when mem_we is high.
   logic [2:0]  ram [FBS];
   logic        ram_ready = 1'b0;
   logic        pre_en    = 1'b0;
   int unsigned pre_addr  = 0;
   logic [2:0]  pre_val   = 3'd0;

   always @(posedge Clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < int'(FBS); i++) ram[i] <= 3'd0;
         ram_ready <= 1'b1;
      end else if (pre_en) begin
         ram[pre_addr] <= pre_val;
      end else if (bus.mem_we && (32'(bus.mem_addr) < FBS)) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= (32'(bus.mem_addr) < FBS) ? ram[bus.mem_addr] : 3'd0;
   end

   // Reference model state.
   typedef struct {
      int unsigned due;
      logic [2:0]  val;
   } rd_t;

   logic [2:0]  exp_img [FBS];
   rd_t         rdq[$];
   int unsigned cyc;
   logic        m_last;
   logic [2:0]  m_pd;
   logic        m_busy;
   int unsigned m_caddr;
   logic        m_read;
   logic        m_clr;
   int          m_pick;
   logic [1:0]  e_ack;
   logic        e_pv;
   logic [2:0]  e_pd;
   logic        r_we;
   logic [AW-1:0] r_addr;
   logic [2:0]  r_wdata;

   // Player stimulus.
   logic [1:0]  p_req;
   logic [9:0]  p_x [2];
   logic [9:0]  p_y [2];
   logic [2:0]  p_d [2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic model_reset();
      rdq.delete();
      m_last  = 1'b1;
      m_pd    = 3'd0;
      m_busy  = 1'b0;
      m_caddr = 0;
      r_we    = 1'b0;
      r_addr  = '0;
      r_wdata = 3'd0;
      cyc     = 0;
   endtask

   // Expected outputs for the current cycle from the current inputs.
   task automatic model_eval();
      m_read = bus.pix_req;
      m_clr  = 1'b0;
      m_pick = -1;
      if (!bus.pix_req) begin
         if (m_busy) m_clr = 1'b1;
         else if (bus.wr_req == 2'b11) m_pick = m_last ? 0 : 1;
         else if (bus.wr_req[0]) m_pick = 0;
         else if (bus.wr_req[1]) m_pick = 1;
      end
      e_ack = (m_pick == 0) ? 2'b01 : (m_pick == 1) ? 2'b10 : 2'b00;
      e_pv  = (rdq.size() > 0) && (rdq[0].due == cyc);
      e_pd  = e_pv ? rdq[0].val : m_pd;
   endtask

   // Advance the model across the clock edge.
   task automatic model_commit();
      int unsigned x, y;
      logic [2:0]  d;
      logic        was_busy;
      was_busy = m_busy;
      if (e_pv) begin
         m_pd = rdq[0].val;
         void'(rdq.pop_front());
      end
      r_we = 1'b0;
      if (m_read) begin
         x = 32'(bus.DrawX);
         y = 32'(bus.DrawY);
         rdq.push_back('{due: cyc + 3, val: (x < H && y < V) ? exp_img[y * H + x] : 3'd0});
      end else if (m_clr) begin
         exp_img[m_caddr] = 3'd0;
         r_we    = 1'b1;
         r_addr  = AW'(m_caddr);
         r_wdata = 3'd0;
         if (m_caddr == FBS - 1) begin
            m_busy  = 1'b0;
            m_caddr = 0;
         end else begin
            m_caddr++;
         end
      end else if (m_pick >= 0) begin
         m_last = (m_pick == 1);
         x = (m_pick == 1) ? 32'(bus.wr_x1) : 32'(bus.wr_x0);
         y = (m_pick == 1) ? 32'(bus.wr_y1) : 32'(bus.wr_y0);
         d = (m_pick == 1) ? bus.wr_data1 : bus.wr_data0;
         if (x < H && y < V) begin
            exp_img[y * H + x] = d;
            r_we    = 1'b1;
            r_addr  = AW'(y * H + x);
            r_wdata = d;
         end
      end
`ifdef FB_CLEAR_EN
      if (!was_busy && bus.clr_start) begin
         m_busy  = 1'b1;
         m_caddr = 0;
      end
`else
      if (was_busy) m_busy = 1'b0;
`endif
      cyc++;
   endtask

   function automatic logic [9:0] rnd_coord(int unsigned lim, bit allow_oor);
      if (allow_oor && $urandom_range(0, 9) == 0)
         return 10'(lim + $urandom_range(0, 1023 - lim));
      return 10'($urandom_range(0, lim - 1));
   endfunction

   task automatic new_req(int i, bit allow_oor);
      p_x[i]   = rnd_coord(H, allow_oor);
      p_y[i]   = rnd_coord(V, allow_oor);
      p_d[i]   = 3'($urandom_range(0, 7));
      p_req[i] = 1'b1;
   endtask

   task automatic drive_players();
      bus.wr_req   = p_req;
      bus.wr_x0    = p_x[0];
      bus.wr_y0    = p_y[0];
      bus.wr_data0 = p_d[0];
      bus.wr_x1    = p_x[1];
      bus.wr_y1    = p_y[1];
      bus.wr_data1 = p_d[1];
   endtask

   task automatic clear_inputs();
      bus.pix_req   = 1'b0;
      bus.DrawX     = '0;
      bus.DrawY     = '0;
      bus.clr_start = 1'b0;
      p_req         = 2'b00;
      for (int i = 0; i < 2; i++) begin
         p_x[i] = '0;
         p_y[i] = '0;
         p_d[i] = '0;
      end
      drive_players();
   endtask

   task automatic apply_reset();
      Reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      model_reset();
   endtask

   // Sample point of a cycle: inputs are settled, outputs are stable.
   task automatic step();
      drive_players();
      @(negedge Clk);
      model_eval();
   endtask

   // Close the cycle: commit the model, retire acked requests, next edge.
   task automatic finish_cycle();
      model_commit();
      for (int i = 0; i < 2; i++) if (e_ack[i]) p_req[i] = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset_n     = 1'b0;
      clear_inputs();
      bus.pix_req = 1'b1;
      p_req       = 2'b11;
      drive_players();
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      n_checks++; if (bus.wr_ack !== 2'b00) begin n_fail++; $display("FAIL reset_wr_ack got=%b exp=00", bus.wr_ack); end
      n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got=%b exp=0", bus.pix_valid); end
      n_checks++; if (bus.pix_data !== 3'd0) begin n_fail++; $display("FAIL reset_pix_data got=%0d exp=0", bus.pix_data); end
      n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
      n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
      n_checks++; if (bus.mem_wdata !== 3'd0) begin n_fail++; $display("FAIL reset_mem_wdata got=%0d exp=0", bus.mem_wdata); end
      n_checks++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy got=%b exp=0", bus.clr_busy); end
      clear_inputs();
   endtask

   task automatic test_read();
      pre_addr = 643;
      pre_val  = 3'd5;
      exp_img[643] = 3'd5;
      pre_en = 1'b1;
      @(posedge Clk);
      #1 pre_en = 1'b0;
      Reset_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         bus.pix_req = (k == 0);
         bus.DrawX   = 10'd3;
         bus.DrawY   = 10'd1;
         step();
         if (k == 1) begin
            n_checks++; if (bus.mem_addr !== AW'(643)) begin n_fail++; $display("FAIL read_mem_addr got=%0d exp=643", bus.mem_addr); end
            n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL read_mem_we got=%b exp=0", bus.mem_we); end
         end
         if (k == 1 || k == 2) begin
            n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL read_early_valid k=%0d got=%b exp=0", k, bus.pix_valid); end
         end
         if (k == 3) begin
            n_checks++; if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL read_pix_valid got=%b exp=1", bus.pix_valid); end
            n_checks++; if (bus.pix_data !== 3'd5) begin n_fail++; $display("FAIL read_pix_data got=%0d exp=5", bus.pix_data); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]    exp_ack;
      logic [AW-1:0] exp_addr;
      logic [2:0]    exp_data;
      apply_reset();
      p_x[0] = 10'd10;  p_y[0] = 10'd2;   p_d[0] = 3'd3;
      p_x[1] = 10'd639; p_y[1] = 10'd479; p_d[1] = 3'd6;
      for (int k = 0; k < 8; k++) begin
         p_req = 2'b11;
         step();
         exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
         n_checks++; if (bus.wr_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, bus.wr_ack, exp_ack); end
         if (k > 0) begin
            exp_addr = (k % 2 == 1) ? AW'(1290) : AW'(307199);
            exp_data = (k % 2 == 1) ? 3'd3 : 3'd6;
            n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rr_mem_we k=%0d got=%b exp=1", k, bus.mem_we); end
            n_checks++; if (bus.mem_addr !== exp_addr) begin n_fail++; $display("FAIL rr_mem_addr k=%0d got=%0d exp=%0d", k, bus.mem_addr, exp_addr); end
            n_checks++; if (bus.mem_wdata !== exp_data) begin n_fail++; $display("FAIL rr_mem_wdata k=%0d got=%0d exp=%0d", k, bus.mem_wdata, exp_data); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_read_priority();
      logic [1:0] exp_ack;
      apply_reset();
      for (int k = 0; k < 40; k++) begin
         bus.pix_req = (k % 2 == 0);
         bus.DrawX   = rnd_coord(H, 1'b0);
         bus.DrawY   = rnd_coord(V, 1'b0);
         if (!p_req[0]) new_req(0, 1'b0);
         step();
         exp_ack = (k % 2 == 1) ? 2'b01 : 2'b00;
         n_checks++; if (bus.wr_ack !== exp_ack) begin n_fail++; $display("FAIL prio_ack k=%0d got=%b exp=%b", k, bus.wr_ack, exp_ack); end
         n_checks++; if (bus.pix_valid !== e_pv) begin n_fail++; $display("FAIL prio_pix_valid k=%0d got=%b exp=%b", k, bus.pix_valid, e_pv); end
         n_checks++; if (bus.pix_data !== e_pd) begin n_fail++; $display("FAIL prio_pix_data k=%0d got=%0d exp=%0d", k, bus.pix_data, e_pd); end
         n_checks++; if (bus.mem_we !== r_we) begin n_fail++; $display("FAIL prio_mem_we k=%0d got=%b exp=%b", k, bus.mem_we, r_we); end
         finish_cycle();
      end
   endtask

   task automatic test_out_of_range();
      apply_reset();
      for (int k = 0; k < 7; k++) begin
         if (k == 0) begin
            p_x[1] = 10'd640; p_y[1] = 10'd0; p_d[1] = 3'd7; p_req[1] = 1'b1;
         end
         bus.pix_req = (k == 1 || k == 2);
         bus.DrawX   = (k == 1) ? 10'd10 : 10'd3;
         bus.DrawY   = (k == 1) ? 10'd2  : 10'd480;
         step();
         if (k == 0) begin
            n_checks++; if (bus.wr_ack !== 2'b10) begin n_fail++; $display("FAIL oor_wr_ack got=%b exp=10", bus.wr_ack); end
         end
         if (k == 1) begin
            n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_mem_we got=%b exp=0", bus.mem_we); end
         end
         if (k == 4) begin
            n_checks++; if (bus.pix_data !== e_pd || bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL oor_prior_read got=%0d/%b exp=%0d/1", bus.pix_data, bus.pix_valid, e_pd); end
         end
         if (k == 5) begin
            n_checks++; if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL oor_pix_valid got=%b exp=1", bus.pix_valid); end
            n_checks++; if (bus.pix_data !== 3'd0) begin n_fail++; $display("FAIL oor_pix_data got=%0d exp=0", bus.pix_data); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 600; k++) begin
         bus.pix_req = 1'($urandom_range(0, 1));
         bus.DrawX   = rnd_coord(H, 1'b1);
         bus.DrawY   = rnd_coord(V, 1'b1);
`ifdef FB_CLEAR_EN
         bus.clr_start = 1'b0;
`else
         bus.clr_start = ($urandom_range(0, 19) == 0);
`endif
         for (int i = 0; i < 2; i++) if (!p_req[i] && $urandom_range(0, 2) != 0) new_req(i, 1'b1);
         step();
         n_checks++; if (bus.wr_ack !== e_ack) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, bus.wr_ack, e_ack); end
         n_checks++; if (bus.pix_valid !== e_pv) begin n_fail++; $display("FAIL rand_pix_valid cyc=%0d got=%b exp=%b", cyc, bus.pix_valid, e_pv); end
         n_checks++; if (bus.pix_data !== e_pd) begin n_fail++; $display("FAIL rand_pix_data cyc=%0d got=%0d exp=%0d", cyc, bus.pix_data, e_pd); end
         n_checks++; if (bus.mem_we !== r_we) begin n_fail++; $display("FAIL rand_mem_we cyc=%0d got=%b exp=%b", cyc, bus.mem_we, r_we); end
         if (r_we) begin
            n_checks++; if (bus.mem_addr !== r_addr || bus.mem_wdata !== r_wdata) begin n_fail++; $display("FAIL rand_mem_cmd cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.mem_addr, bus.mem_wdata, r_addr, r_wdata); end
         end
         n_checks++; if (bus.clr_busy !== m_busy) begin n_fail++; $display("FAIL rand_clr_busy cyc=%0d got=%b exp=%b", cyc, bus.clr_busy, m_busy); end
         finish_cycle();
      end
   endtask

`ifdef FB_CLEAR_EN
   task automatic test_clear();
      apply_reset();
      bus.clr_start = 1'b1;
      new_req(0, 1'b0);
      step();
      n_checks++; if (bus.wr_ack !== 2'b01) begin n_fail++; $display("FAIL clr_start_ack got=%b exp=01", bus.wr_ack); end
      n_checks++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_busy got=%b exp=0", bus.clr_busy); end
      finish_cycle();
      for (int k = 1; k < 1500; k++) begin
         bus.clr_start = (k == 700);
         bus.pix_req   = (k % 2 == 0);
         bus.DrawX     = rnd_coord(H, 1'b0);
         bus.DrawY     = rnd_coord(V, 1'b0);
         if (!p_req[0]) new_req(0, 1'b0);
         step();
         n_checks++; if (bus.clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy k=%0d got=%b exp=1", k, bus.clr_busy); end
         n_checks++; if (bus.wr_ack !== 2'b00) begin n_fail++; $display("FAIL clr_wr_ack k=%0d got=%b exp=00", k, bus.wr_ack); end
         n_checks++; if (bus.mem_we !== r_we) begin n_fail++; $display("FAIL clr_mem_we k=%0d got=%b exp=%b", k, bus.mem_we, r_we); end
         if (r_we) begin
            n_checks++; if (bus.mem_addr !== r_addr || bus.mem_wdata !== r_wdata) begin n_fail++; $display("FAIL clr_mem_cmd k=%0d got=%0d/%0d exp=%0d/%0d", k, bus.mem_addr, bus.mem_wdata, r_addr, r_wdata); end
         end
         n_checks++; if (bus.pix_valid !== e_pv || bus.pix_data !== e_pd) begin n_fail++; $display("FAIL clr_pix k=%0d got=%b/%0d exp=%b/%0d", k, bus.pix_valid, bus.pix_data, e_pv, e_pd); end
         finish_cycle();
      end
      Reset_n = 1'b0;
      #1;
      n_checks++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_reset_busy got=%b exp=0", bus.clr_busy); end
      n_checks++; if (bus.wr_ack !== 2'b00) begin n_fail++; $display("FAIL clr_reset_ack got=%b exp=00", bus.wr_ack); end
      apply_reset();
   endtask
`else
   task automatic test_clear_disabled();
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         bus.clr_start = (k == 0);
         new_req(0, 1'b0);
         step();
         n_checks++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL nclr_busy k=%0d got=%b exp=0", k, bus.clr_busy); end
         n_checks++; if (bus.wr_ack !== 2'b01) begin n_fail++; $display("FAIL nclr_ack k=%0d got=%b exp=01", k, bus.wr_ack); end
         if (k == 1) begin
            n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== r_addr) begin n_fail++; $display("FAIL nclr_mem got=%b/%0d exp=1/%0d", bus.mem_we, bus.mem_addr, r_addr); end
         end
         finish_cycle();
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < int'(FBS); i++) exp_img[i] = 3'd0;
      model_reset();
      clear_inputs();
      test_reset();
      test_read();
      test_round_robin();
      test_read_priority();
      test_out_of_range();
      test_random();
`ifdef FB_CLEAR_EN
      test_clear();
`else
      test_clear_disabled();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
